// File: rtl/imem_stream_loader.sv
// Instruction memory with a streaming program loader.
// A load stream fills the memory from word 0 upward while the core is held.
// The core fetch port returns a registered instruction word one cycle after the address.
module imem_stream_loader #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                A,
  output logic [31:0]                RD,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [31:0]                load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       core_hold,
  output logic                       load_done,
  output logic                       load_err,
  output logic [$clog2(DEPTH):0]     load_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          hold_q, hold_d;
  logic [31:0]   rd_q, rd_d;
  logic          wr_en_c;
  logic [31:0]   word_addr_c;
  logic          out_of_range_c;
  logic [AW-1:0] rd_idx_c;
  logic [AW-1:0] wr_idx_c;

  logic [31:0]   mem_q [DEPTH];

  // Fetch address decode: byte offset bits are dropped by the shift.
  assign word_addr_c    = A >> 2;
  assign out_of_range_c = (word_addr_c >= 32'(DEPTH));
  assign rd_idx_c       = word_addr_c[AW-1:0];
  assign wr_idx_c       = cnt_q[AW-1:0];

  // Next-state, write enable and fetch value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en_c = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          // Restart: the beat presented this cycle is discarded.
          cnt_d = '0;
          err_d = 1'b0;
        end else if (load_valid) begin
          // The write pointer and the stored-word count are the same value.
          if (cnt_q < CW'(DEPTH)) begin
            wr_en_c = 1'b1;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
          if (load_last) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    hold_d = (state_d == S_LOAD);
    done_d = (state_d == S_DONE);
    if (hold_q || out_of_range_c) begin
      rd_d = NOP_WORD;
    end else begin
      rd_d = mem_q[rd_idx_c];
    end
  end

  // Control and fetch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b0;
      rd_q    <= NOP_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      rd_q    <= rd_d;
    end
  end

  // Memory array: no reset so contents survive both reset and reload.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_idx_c] <= load_data;
    end
  end

  assign RD         = rd_q;
  assign load_ready = hold_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign load_count = cnt_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: two instances (DEPTH 64 and 4) share one stimulus
// stream and are checked every cycle against a behavioural model, plus pinned literals.
module tb_imem_stream_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;

  logic [31:0] rd64, rd4;
  logic        rdy64, rdy4, hold64, hold4, done64, done4, err64, err4;
  logic [6:0]  cnt64;
  logic [2:0]  cnt4;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = DEPTH 64, index 1 = DEPTH 4.
  int          m_depth [2] = '{64, 4};
  bit          m_load  [2];
  bit          m_done  [2];
  bit          m_err   [2];
  int          m_cnt   [2];
  logic [31:0] m_mem   [2][64];
  bit          m_memv  [2][64];
  logic [31:0] m_rd    [2];
  bit          m_rdk   [2];

  imem_stream_loader #(.DEPTH(64), .NOP_WORD(NOP)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .A(A), .RD(rd64),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(rdy64), .core_hold(hold64),
    .load_done(done64), .load_err(err64), .load_count(cnt64)
  );

  imem_stream_loader #(.DEPTH(4), .NOP_WORD(NOP)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .A(A), .RD(rd4),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(rdy4), .core_hold(hold4),
    .load_done(done4), .load_err(err4), .load_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Behavioural update of one model instance at a rising edge.
  task automatic model_edge(input int k);
    int w;
    if (!rst_n) begin
      m_load[k] = 0; m_done[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      m_rd[k] = NOP; m_rdk[k] = 1;
      return;
    end
    w = int'(A >> 2);
    if (m_load[k] || (A >> 2) >= 32'(m_depth[k])) begin
      m_rd[k] = NOP; m_rdk[k] = 1;
    end else begin
      m_rd[k] = m_mem[k][w]; m_rdk[k] = m_memv[k][w];
    end
    if (!m_load[k]) begin
      if (load_start) begin
        m_load[k] = 1; m_done[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      end
    end else if (load_start) begin
      m_cnt[k] = 0; m_err[k] = 0;
    end else if (load_valid) begin
      if (m_cnt[k] < m_depth[k]) begin
        m_mem[k][m_cnt[k]] = load_data;
        m_memv[k][m_cnt[k]] = 1;
        m_cnt[k]++;
      end else begin
        m_err[k] = 1;
      end
      if (load_last) begin
        m_load[k] = 0; m_done[k] = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("ready64", 32'(rdy64), 32'(m_load[0]));
    chk("hold64",  32'(hold64), 32'(m_load[0]));
    chk("done64",  32'(done64), 32'(m_done[0]));
    chk("err64",   32'(err64),  32'(m_err[0]));
    chk("count64", 32'(cnt64),  32'(m_cnt[0]));
    if (m_rdk[0]) chk("rd64", rd64, m_rd[0]);
    chk("ready4",  32'(rdy4),  32'(m_load[1]));
    chk("hold4",   32'(hold4), 32'(m_load[1]));
    chk("done4",   32'(done4), 32'(m_done[1]));
    chk("err4",    32'(err4),  32'(m_err[1]));
    chk("count4",  32'(cnt4),  32'(m_cnt[1]));
    if (m_rdk[1]) chk("rd4", rd4, m_rd[1]);
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    A = addr; tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) m_memv[k][i] = 0;

    // Reset then fetch out of range.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    fetch(32'h100);
    chk("rst_rd64", rd64, 32'h0000_0013);
    chk("rst_flags", {28'd0, hold64, done64, err64, rdy64}, 32'd0);
    chk("rst_cnt", 32'(cnt64), 32'd0);

    // Basic load of four words, then fetch word 2.
    A = 32'h0;
    start();
    chk("basic_hold", 32'(hold64), 32'd1);
    beat(32'h0050_0093, 1'b0);
    beat(32'h0010_0113, 1'b0);
    beat(32'h0020_81B3, 1'b0);
    chk("basic_hold_late", 32'(hold64), 32'd1);
    beat(32'h0000_006F, 1'b1);
    chk("basic_done", 32'(done64), 32'd1);
    chk("basic_cnt", 32'(cnt64), 32'd4);
    fetch(32'h8);
    chk("basic_rd8", rd64, 32'h0020_81B3);
    fetch(32'hB);
    chk("basic_rd_ofs", rd64, 32'h0020_81B3);

    // Bubbles between beats.
    start();
    beat(32'hAAAA_0001, 1'b0); tick();
    beat(32'hAAAA_0002, 1'b0); tick();
    beat(32'hAAAA_0003, 1'b1);
    chk("bubble_cnt", 32'(cnt64), 32'd3);
    fetch(32'h0); chk("bubble_w0", rd64, 32'hAAAA_0001);
    fetch(32'h4); chk("bubble_w1", rd64, 32'hAAAA_0002);
    fetch(32'h8); chk("bubble_w2", rd64, 32'hAAAA_0003);
    fetch(32'hC); chk("bubble_w3_kept", rd64, 32'h0000_006F);

    // Overflow on the DEPTH-4 instance.
    start();
    for (int i = 1; i <= 6; i++) beat(32'hB000_0000 + 32'(i), i == 6);
    chk("ovf_err4", 32'(err4), 32'd1);
    chk("ovf_cnt4", 32'(cnt4), 32'd4);
    chk("ovf_done4", 32'(done4), 32'd1);
    chk("ovf_err64", 32'(err64), 32'd0);
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      chk("ovf_mem4", rd4, 32'hB000_0001 + 32'(i));
    end
    fetch(32'h10); chk("ovf_oor4", rd4, NOP);

    // Restart mid-load.
    start();
    beat(32'hC000_0001, 1'b0);
    beat(32'hC000_0002, 1'b0);
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF; start(); load_valid = 1'b0;
    beat(32'hC000_0003, 1'b1);
    chk("restart_cnt", 32'(cnt64), 32'd1);
    fetch(32'h0); chk("restart_w0", rd64, 32'hC000_0003);

    // Reset mid-load.
    start();
    beat(32'hD000_0001, 1'b0);
    beat(32'hD000_0002, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_hold", 32'(hold64), 32'd0);
    chk("rstmid_done", 32'(done64), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    load_valid = 1'b1; load_data = 32'hEEEE_EEEE; tick(); load_valid = 1'b0;
    chk("rstmid_noaccept", 32'(cnt64), 32'd0);
    fetch(32'h0); chk("rstmid_w0", rd64, 32'hD000_0001);
    fetch(32'h4); chk("rstmid_w1", rd64, 32'hD000_0002);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      load_start = ($urandom_range(0, 29) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_last  = ($urandom_range(0, 11) == 0);
      load_data  = $urandom;
      A          = (n % 3 == 0) ? $urandom : 32'($urandom_range(0, 32'h120));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
IMEM_STREAM_LOADER -- requirements
Module: imem_stream_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit instruction words (power of 2, at least 4).
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h00000013, giving the instruction returned for out-of-range or held fetches.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port A, input, 32 bits: fetch byte address (PC).
REQ-006 The block SHALL have port RD, output, 32 bits: fetched instruction, registered.
REQ-007 The block SHALL have port load_start, input, 1 bit: single-cycle pulse that begins a program load.
REQ-008 The block SHALL have port load_valid, input, 1 bit: a load word is present on load_data.
REQ-009 The block SHALL have port load_data, input, 32 bits: load word.
REQ-010 The block SHALL have port load_last, input, 1 bit: qualifies the final word of the load.
REQ-011 The block SHALL have port load_ready, output, 1 bit: the block accepts a load word this cycle.
REQ-012 The block SHALL have port core_hold, output, 1 bit: processor stall request while a load is in progress.
REQ-013 The block SHALL have port load_done, output, 1 bit: sticky flag, load completed.
REQ-014 The block SHALL have port load_err, output, 1 bit: sticky flag, load overflowed DEPTH.
REQ-015 The block SHALL have port load_count, output, clog2(DEPTH)+1 bits: number of words stored by the current or last load.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD and DONE.
REQ-017 The FSM SHALL make these transitions:
- IDLE -> LOAD on load_start.
- LOAD -> DONE on an accepted beat with load_last=1.
- DONE -> LOAD on load_start.
REQ-018 Entering LOAD SHALL clear the write pointer, load_count, load_done and load_err.
REQ-019 A load_start asserted while in LOAD SHALL restart the load: the pointer and count are cleared, and that cycle's beat is discarded.
REQ-020 load_ready SHALL equal 1 exactly when the state is LOAD.
REQ-021 A beat SHALL be accepted when load_valid=1 and load_ready=1, with no other qualifier.
REQ-022 Each accepted beat while pointer < DEPTH SHALL:
- write load_data to mem[pointer];
- increment the pointer;
- increment load_count.
REQ-023 An accepted beat while pointer = DEPTH SHALL be dropped without writing and SHALL set load_err.
- After overflow, load_ready stays 1 so the source can drain to load_last.
- load_count saturates at DEPTH.
REQ-024 core_hold SHALL equal 1 in LOAD and 0 in IDLE and DONE.
REQ-025 load_done SHALL be 1 in DONE and 0 otherwise; it rises in the cycle after the last beat is accepted.
REQ-026 RD SHALL be registered with one-cycle latency: at each rising edge, RD <= the fetch value defined in REQ-027.
REQ-027 The fetch value SHALL be:
- NOP_WORD if core_hold is 1;
- NOP_WORD if A[31:2] >= DEPTH;
- mem[A[31:2]] otherwise.
REQ-028 A[1:0] SHALL be ignored.
REQ-029 Memory contents SHALL persist across loads and across reset.
- Words beyond load_count keep prior contents.
- Words never written read as X in simulation; the bench does not check them.

Reset
REQ-030 While rst_n=0, the block SHALL hold state=IDLE, RD=NOP_WORD, load_ready=0, core_hold=0, load_done=0, load_err=0 and load_count=0.
REQ-031 Reset asserted during LOAD SHALL abort the load immediately to IDLE.
- Words already written remain in memory.
- No write occurs in the reset cycle.
REQ-032 After rst_n deasserts, the block SHALL require load_start before accepting any load beat.

Verification
REQ-033 Reset then fetch: hold rst_n=0 for 3 cycles, release, drive A=0x100 (word 64, DEPTH=64) -> RD=0x00000013 one cycle later; all flags 0.
REQ-034 Basic load and fetch:
- Stimulus: load_start, then 4 back-to-back beats 0x00500093, 0x00100113, 0x002081B3, 0x0000006F, with load_last on the 4th; afterwards A=0x8.
- Response: core_hold=1 from the cycle after load_start through the 4th beat; load_done=1 and load_count=4 the next cycle; RD=0x002081B3 one cycle after A=0x8 is applied.
REQ-035 Bubbles in the stream: toggle load_valid 1/0 across 3 beats -> only valid cycles write; load_count=3; word order is preserved.
REQ-036 Overflow (DEPTH=4): stream 6 beats, load_last on the 6th -> load_err=1, load_count=4, mem[0..3] hold beats 1-4, load_done=1.
REQ-037 Restart mid-load: send 2 beats, pulse load_start, send 1 beat with load_last=1 -> load_count=1 and that word is at mem[0].
REQ-038 Reset mid-load: send 2 beats, assert rst_n=0 -> state IDLE, core_hold=0, load_done=0; after release, mem[0..1] still hold the 2 words.
